// File: rtl/mdu_if.sv
// Bundle between the EX stage and the multiply/divide unit: forwarded operands,
// the MD request, and the architectural HI/LO plus busy status back.
interface mdu_if;
  logic [31:0] A;
  logic [31:0] B;
  logic        md_valid;
  logic [3:0]  MD_OP;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        dbg_state;

  // md_valid is a single-cycle request sampled at a rising edge. busy=1 means
  // not ready, except on the final RUN edge, where a new request is accepted.
  modport master (
    output A, B, md_valid, MD_OP,
    input  busy, HI, LO, dbg_state
  );

  modport slave (
    input  A, B, md_valid, MD_OP,
    output busy, HI, LO, dbg_state
  );
endinterface

// File: rtl/mdu.sv
// EX-stage multiply/divide unit with fixed-latency writeback into HI/LO.
// Define MDU_MADD_EN to build madd/maddu/msub/msubu; otherwise codes 7-10 are ignored.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic  clk,
  input logic  reset,
  mdu_if.slave md
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [63:0]   pend_q, pend_d;
  logic          skip_wb_q, skip_wb_d;

  logic          last_cycle;
  logic          can_issue;
  logic [63:0]   hilo_fwd;

  logic          mul_signed;
  logic [63:0]   mul_a, mul_b, prod;

  logic          div_signed;
  logic [31:0]   div_b, dvd, dvs, q_mag, r_mag, quo, rem;

  assign last_cycle = (state_q == S_RUN) && (cnt_q == CNT_ONE);
  assign can_issue  = (state_q == S_IDLE) || last_cycle;

  // HI/LO as they stand after this edge's writeback; accumulate ops issuing on
  // the completion edge must see these, not the stale registers.
  assign hilo_fwd = (last_cycle && !skip_wb_q) ? pend_q : {hi_q, lo_q};

`ifdef MDU_MADD_EN
  assign mul_signed = (md.MD_OP == OP_MULT) || (md.MD_OP == OP_MADD) ||
                      (md.MD_OP == OP_MSUB);
`else
  assign mul_signed = (md.MD_OP == OP_MULT);
`endif

  // One shared 64-bit multiplier; the low 64 bits of the extended product are
  // exact for both signed and unsigned operands.
  assign mul_a = {{32{mul_signed & md.A[31]}}, md.A};
  assign mul_b = {{32{mul_signed & md.B[31]}}, md.B};
  assign prod  = mul_a * mul_b;

  // Divider works on magnitudes; signs are restored afterwards. A zero divisor
  // is replaced so the datapath stays defined; that result is never written.
  assign div_signed = (md.MD_OP == OP_DIV);
  assign div_b      = (md.B == 32'd0) ? 32'd1 : md.B;
  assign dvd        = (div_signed && md.A[31]) ? (32'd0 - md.A) : md.A;
  assign dvs        = (div_signed && div_b[31]) ? (32'd0 - div_b) : div_b;
  assign q_mag      = dvd / dvs;
  assign r_mag      = dvd % dvs;
  assign quo        = (div_signed && (md.A[31] ^ div_b[31])) ? (32'd0 - q_mag) : q_mag;
  assign rem        = (div_signed && md.A[31]) ? (32'd0 - r_mag) : r_mag;

`ifdef MDU_MADD_EN
  logic [63:0] acc_add, acc_sub;
  assign acc_add = hilo_fwd + prod;
  assign acc_sub = hilo_fwd - prod;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    skip_wb_d = skip_wb_q;
    hi_d      = hilo_fwd[63:32];
    lo_d      = hilo_fwd[31:0];

    if (state_q == S_RUN) begin
      cnt_d = cnt_q - CNT_ONE;
      if (last_cycle) begin
        state_d = S_IDLE;
      end
    end

    if (md.md_valid && can_issue) begin
      case (md.MD_OP)
        OP_MTHI: hi_d = md.A;
        OP_MTLO: lo_d = md.A;
        OP_MULT, OP_MULTU: begin
          state_d   = S_RUN;
          cnt_d     = MULT_LOAD;
          pend_d    = prod;
          skip_wb_d = 1'b0;
        end
        OP_DIV, OP_DIVU: begin
          state_d   = S_RUN;
          cnt_d     = DIV_LOAD;
          pend_d    = {rem, quo};
          skip_wb_d = (md.B == 32'd0);
        end
`ifdef MDU_MADD_EN
        OP_MADD, OP_MADDU: begin
          state_d   = S_RUN;
          cnt_d     = MULT_LOAD;
          pend_d    = acc_add;
          skip_wb_d = 1'b0;
        end
        OP_MSUB, OP_MSUBU: begin
          state_d   = S_RUN;
          cnt_d     = MULT_LOAD;
          pend_d    = acc_sub;
          skip_wb_d = 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_q    <= '0;
      skip_wb_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_q    <= pend_d;
      skip_wb_q <= skip_wb_d;
    end
  end

  assign md.busy      = (state_q == S_RUN);
  assign md.HI        = hi_q;
  assign md.LO        = lo_q;
  assign md.dbg_state = state_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: vector table, random mult/divu, and hand-written
// sequences for ignored/late issue, reset abort and the accumulate ops.
module tb_mdu;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdu_if md_bus ();

  mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md_bus)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] cur_hl;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        keep;
    logic [63:0] exp_hl;
    int          cycles;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge: request is sampled at the next posedge; returns at the
  // following negedge.
  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    md_bus.md_valid = 1'b1;
    md_bus.MD_OP    = op;
    md_bus.A        = a;
    md_bus.B        = b;
    @(negedge clk);
    md_bus.md_valid = 1'b0;
    md_bus.MD_OP    = OP_NONE;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (md_bus.busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_vec(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic keep, input logic [63:0] exp,
                         input int cycles);
    logic [63:0] e;
    int n;
    exp_q.push_back(keep ? cur_hl : exp);
    drive(op, a, b);
    if (cycles > 0) check({name, " hold"}, {md_bus.HI, md_bus.LO}, cur_hl);
    wait_done(n);
    check({name, " cycles"}, 64'(n), 64'(cycles));
    e = exp_q.pop_front();
    check(name, {md_bus.HI, md_bus.LO}, e);
    cur_hl = e;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [3:0] op;
    logic [31:0] a, b;
    logic signed [63:0] sa, sb;
    logic [63:0] e;

    vecs[0]  = '{OP_MULT,  32'hFFFFFFFE, 32'd3,        1'b0, 64'hFFFFFFFF_FFFFFFFA, MULT_N};
    vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'd2,        1'b0, 64'h00000001_FFFFFFFE, MULT_N};
    vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        1'b0, 64'hFFFFFFFF_FFFFFFFD, DIV_N};
    vecs[3]  = '{OP_DIVU,  32'h00012345, 32'd0,        1'b1, 64'h0,                 DIV_N};
    vecs[4]  = '{OP_DIVU,  32'd100,      32'd7,        1'b0, 64'h00000002_0000000E, DIV_N};
    vecs[5]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 1'b0, 64'h00000000_80000000, DIV_N};
    vecs[6]  = '{OP_MULT,  32'h80000000, 32'h80000000, 1'b0, 64'h40000000_00000000, MULT_N};
    vecs[7]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 1'b0, 64'h00000001_FFFFFFFD, DIV_N};
    vecs[8]  = '{OP_MULTU, 32'h00010000, 32'h00010000, 1'b0, 64'h00000001_00000000, MULT_N};
    vecs[9]  = '{OP_DIV,   32'd5,        32'd0,        1'b1, 64'h0,                 DIV_N};
    vecs[10] = '{OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 1'b0, 64'hFFFFFFFF_00000003, DIV_N};
    vecs[11] = '{4'd15,    32'h11111111, 32'h2,        1'b1, 64'h0,                 0};
    vecs[12] = '{OP_NONE,  32'h22222222, 32'h3,        1'b1, 64'h0,                 0};

    reset = 1'b1;
    md_bus.md_valid = 1'b0;
    md_bus.MD_OP = OP_NONE;
    md_bus.A = '0;
    md_bus.B = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cur_hl = 64'h0;
    check("reset busy", 64'(md_bus.busy), 64'h0);
    check("reset hilo", {md_bus.HI, md_bus.LO}, 64'h0);

    for (int i = 0; i < 13; i++)
      run_vec($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
              vecs[i].keep, vecs[i].exp_hl, vecs[i].cycles);

    for (int i = 0; i < 8; i++) begin
      op = 4'($urandom_range(1, 4));
      if (op == OP_DIV) op = OP_DIVU;
      a = $urandom;
      b = (op == OP_DIVU) ? 32'($urandom_range(1, 5000)) : $urandom;
      if (op == OP_MULT) begin
        sa = $signed(a);
        sb = $signed(b);
        e = 64'(sa * sb);
      end else if (op == OP_MULTU) begin
        e = {32'h0, a} * {32'h0, b};
      end else begin
        e = {a % b, a / b};
      end
      run_vec($sformatf("rand%0d", i), op, a, b, 1'b0, e,
              (op == OP_DIVU) ? DIV_N : MULT_N);
    end

    // mthi while busy (not the final edge) is dropped
    exp_q.push_back(64'h00000000_0000000C);
    drive(OP_MULT, 32'd3, 32'd4);
    drive(OP_MTHI, 32'h12345678, 32'd0);
    wait_done(n);
    check("ignored mthi cycles", 64'(n), 64'(MULT_N - 1));
    e = exp_q.pop_front();
    check("ignored mthi hilo", {md_bus.HI, md_bus.LO}, e);
    cur_hl = e;

    drive(OP_MTHI, 32'h12345678, 32'd0);
    check("mthi busy", 64'(md_bus.busy), 64'h0);
    check("mthi hilo", {md_bus.HI, md_bus.LO}, {32'h12345678, cur_hl[31:0]});
    cur_hl[63:32] = 32'h12345678;
    drive(OP_MTLO, 32'hCAFEBABE, 32'd0);
    check("mtlo busy", 64'(md_bus.busy), 64'h0);
    check("mtlo hilo", {md_bus.HI, md_bus.LO}, {32'h12345678, 32'hCAFEBABE});
    cur_hl[31:0] = 32'hCAFEBABE;

    // issue accepted on the writeback edge
    drive(OP_MULT, 32'd2, 32'd3);
    repeat (4) @(negedge clk);
    check("late busy", 64'(md_bus.busy), 64'h1);
    drive(OP_MTHI, 32'hAAAA5555, 32'd0);
    check("late mthi busy", 64'(md_bus.busy), 64'h0);
    check("late mthi hilo", {md_bus.HI, md_bus.LO}, {32'hAAAA5555, 32'h6});
    cur_hl = {32'hAAAA5555, 32'h6};

    // reset during the 4th busy cycle of a divide
    drive(OP_DIV, 32'd100, 32'd3);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", 64'(md_bus.busy), 64'h0);
    check("abort hilo", {md_bus.HI, md_bus.LO}, 64'h0);
    repeat (15) @(negedge clk);
    check("abort late busy", 64'(md_bus.busy), 64'h0);
    check("abort late hilo", {md_bus.HI, md_bus.LO}, 64'h0);
    cur_hl = 64'h0;

    drive(OP_MTHI, 32'h0, 32'd0);
    drive(OP_MTLO, 32'hFFFFFFFF, 32'd0);
    cur_hl = {32'h0, 32'hFFFFFFFF};
`ifdef MDU_MADD_EN
    run_vec("maddu", OP_MADDU, 32'd1, 32'd1, 1'b0, 64'h00000001_00000000, MULT_N);
    run_vec("msub", OP_MSUB, 32'd1, 32'd1, 1'b0, 64'h00000000_FFFFFFFF, MULT_N);
    run_vec("madd neg", OP_MADD, 32'hFFFFFFFF, 32'd2, 1'b0, 64'h00000000_FFFFFFFD, MULT_N);
    // madd on the writeback edge accumulates onto the just-written result
    drive(OP_MULT, 32'd2, 32'd3);
    repeat (4) @(negedge clk);
    drive(OP_MADD, 32'd1, 32'd1);
    wait_done(n);
    check("fwd madd cycles", 64'(n), 64'(MULT_N));
    check("fwd madd hilo", {md_bus.HI, md_bus.LO}, 64'h7);
`else
    drive(OP_MADDU, 32'd1, 32'd1);
    check("maddu off busy", 64'(md_bus.busy), 64'h0);
    check("maddu off hilo", {md_bus.HI, md_bus.LO}, cur_hl);
    repeat (6) @(negedge clk);
    check("maddu off late hilo", {md_bus.HI, md_bus.LO}, cur_hl);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
